// File: rtl/axis_bench_engine.sv
// AXI-Stream benchmark engine: numbered packet generator, return-stream checker,
// loopback pass-through and a small register port with saturating counters.
module axis_bench_engine #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128,
  parameter logic [23:0] MAGIC_CODE = 24'haecafe
) (
  input  logic                    ACLK,
  input  logic                    RESET,
  input  logic                    reg_wr,
  input  logic                    reg_rd,
  input  logic [2:0]              reg_addr,
  input  logic [31:0]             reg_wdata,
  output logic [31:0]             reg_rdata,
  output logic                    M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [USER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                    M_AXIS_TLAST,
  input  logic                    M_AXIS_TREADY,
  input  logic                    S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [USER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned NL   = DATA_WIDTH / 32;
  localparam logic [31:0] NL32 = 32'(NL);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nx;

  logic [31:0] pkt_len, pkt_cnt, len_eff, last_idx;
  logic        mode_run, abort_pending;
  logic [31:0] tx_word, rx_word, tx_idx, rx_idx, tx_pkts, rx_pkts;
  logic [31:0] tx_beats, rx_beats, cycles, err_cnt;
  logic        err_flag;

  logic ctrl_wr, start_go, clear_req, abort_req, abort_eff;
  logic m_hs, s_hs, tx_last_hs, final_pkt, lb_idle_abort;
  logic rx_exp_last, rx_end, beat_err;
  logic [DATA_WIDTH-1:0] gen_data, rx_exp_data;
  logic [USER_WIDTH-1:0] gen_user;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  assign ctrl_wr   = reg_wr && (reg_addr == 3'd0);
  assign start_go  = ctrl_wr && reg_wdata[0] && (state == ST_IDLE || state == ST_DONE);
  assign clear_req = ctrl_wr && reg_wdata[2];
  assign abort_req = ctrl_wr && reg_wdata[3];
  assign abort_eff = abort_pending || abort_req;

  assign len_eff  = (pkt_len == '0) ? 32'd1 : pkt_len;
  assign last_idx = len_eff - 32'd1;

  always_comb begin
    gen_data    = '0;
    rx_exp_data = '0;
    for (int unsigned k = 0; k < NL; k++) begin
      gen_data[32*k +: 32]    = tx_word + k;
      rx_exp_data[32*k +: 32] = rx_word + k;
    end
    gen_user        = '0;
    gen_user[23:0]  = MAGIC_CODE;
    gen_user[39:24] = pkt_len[15:0];
  end

  assign m_hs       = M_AXIS_TVALID && M_AXIS_TREADY;
  assign s_hs       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign tx_last_hs = m_hs && M_AXIS_TLAST;
  assign final_pkt  = (pkt_cnt != '0) && ((tx_pkts + 32'd1) >= pkt_cnt);
  // Loopback has no beat of its own to finish, so abort between packets ends at once.
  assign lb_idle_abort = mode_run && abort_eff && (tx_idx == '0) && !S_AXIS_TVALID;

  assign rx_exp_last = (rx_idx >= last_idx);
  assign rx_end      = mode_run ? S_AXIS_TLAST : rx_exp_last;
  assign beat_err    = s_hs && !mode_run &&
                       ((S_AXIS_TDATA != rx_exp_data) || (S_AXIS_TLAST != rx_exp_last) ||
                        ((rx_idx == '0) && (S_AXIS_TUSER[23:0] != MAGIC_CODE)));

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (start_go) state_nx = ST_RUN;
      ST_RUN:   if ((tx_last_hs && (final_pkt || abort_eff)) || lb_idle_abort) state_nx = ST_DRAIN;
      ST_DRAIN: if (abort_req || (rx_pkts == tx_pkts)) state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TSTRB  = '0;
    M_AXIS_TUSER  = '0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mode_run) begin
          M_AXIS_TVALID = S_AXIS_TVALID;
          M_AXIS_TDATA  = S_AXIS_TDATA;
          M_AXIS_TSTRB  = S_AXIS_TSTRB;
          M_AXIS_TUSER  = S_AXIS_TUSER;
          M_AXIS_TLAST  = S_AXIS_TLAST;
          S_AXIS_TREADY = M_AXIS_TREADY;
        end else begin
          M_AXIS_TVALID = 1'b1;
          M_AXIS_TDATA  = gen_data;
          M_AXIS_TSTRB  = '1;
          M_AXIS_TUSER  = gen_user;
          M_AXIS_TLAST  = (tx_idx >= last_idx);
          S_AXIS_TREADY = 1'b1;
        end
      end
      ST_DRAIN: S_AXIS_TREADY = !mode_run;
      default: ;
    endcase
    busy = (state == ST_RUN) || (state == ST_DRAIN);
    done = (state == ST_DONE);
  end

  assign err = err_flag;

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      pkt_len       <= 32'd1;
      pkt_cnt       <= 32'd1;
      mode_run      <= 1'b0;
      abort_pending <= 1'b0;
      tx_word       <= '0;
      rx_word       <= '0;
      tx_idx        <= '0;
      rx_idx        <= '0;
      tx_pkts       <= '0;
      rx_pkts       <= '0;
    end else begin
      if (reg_wr && reg_addr == 3'd1) pkt_len <= reg_wdata;
      if (reg_wr && reg_addr == 3'd2) pkt_cnt <= reg_wdata;
      if (start_go) begin
        mode_run      <= reg_wdata[1];
        abort_pending <= 1'b0;
        tx_word       <= '0;
        rx_word       <= '0;
        tx_idx        <= '0;
        rx_idx        <= '0;
        tx_pkts       <= '0;
        rx_pkts       <= '0;
      end else begin
        if (m_hs) begin
          tx_word <= tx_word + NL32;
          tx_idx  <= M_AXIS_TLAST ? '0 : tx_idx + 32'd1;
          if (M_AXIS_TLAST) tx_pkts <= tx_pkts + 32'd1;
        end
        if (s_hs) begin
          rx_word <= rx_word + NL32;
          rx_idx  <= rx_end ? '0 : rx_idx + 32'd1;
          if (rx_end) rx_pkts <= rx_pkts + 32'd1;
        end
        if (abort_req && state == ST_RUN) abort_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      tx_beats <= '0;
      rx_beats <= '0;
      cycles   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clear_req) begin
      tx_beats <= '0;
      rx_beats <= '0;
      cycles   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      if (m_hs)     tx_beats <= sat_inc(tx_beats);
      if (s_hs)     rx_beats <= sat_inc(rx_beats);
      if (start_go) cycles   <= '0;
      else if (busy) cycles  <= sat_inc(cycles);
      if (beat_err) begin
        err_cnt  <= sat_inc(err_cnt);
        err_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      reg_rdata <= '0;
    end else if (reg_rd) begin
      unique case (reg_addr)
        3'd1:    reg_rdata <= pkt_len;
        3'd2:    reg_rdata <= pkt_cnt;
        3'd3:    reg_rdata <= {29'b0, err_flag, done, busy};
        3'd4:    reg_rdata <= tx_beats;
        3'd5:    reg_rdata <= rx_beats;
        3'd6:    reg_rdata <= cycles;
        3'd7:    reg_rdata <= err_cnt;
        default: reg_rdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bench_engine.sv
// Directed bench for axis_bench_engine: a beat-numbering model checks both streams
// every cycle, and literal expectations pin counters and status after each run.
module tb_axis_bench_engine;

  localparam logic [23:0] MAGIC = 24'haecafe;

  logic         clk = 1'b0;
  logic         rst;
  logic         reg_wr, reg_rd;
  logic [2:0]   reg_addr;
  logic [31:0]  reg_wdata, reg_rdata;
  logic         m_tvalid, m_tlast, m_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         s_tvalid, s_tlast, s_tready;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         busy, done_o, err_o;

  int unsigned total = 0, bad = 0;
  int unsigned n_tx, n_rx, tx_m, rx_m, err_m, len_m;
  int unsigned src_idx;
  logic        rt_lb = 1'b0, stall = 1'b0, corrupt = 1'b0, gen_chk = 1'b0, src_hs = 1'b0;
  logic        prev_v, prev_r;
  logic [255:0] prev_d;
  logic [31:0] lane0_b1, last_mask, rd;

  axis_bench_engine #(.DATA_WIDTH(256), .USER_WIDTH(128), .MAGIC_CODE(MAGIC)) dut (
    .ACLK(clk), .RESET(rst),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb),
    .M_AXIS_TUSER(m_tuser), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb),
    .S_AXIS_TUSER(s_tuser), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .busy(busy), .done(done_o), .err(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_beat(input int unsigned n);
    logic [255:0] b;
    for (int unsigned k = 0; k < 8; k++) b[32*k +: 32] = n * 8 + k;
    return b;
  endfunction

  function automatic logic [127:0] exp_user();
    logic [127:0] u;
    u = '0;
    u[23:0]  = MAGIC;
    u[39:24] = len_m[15:0];
    return u;
  endfunction

  function automatic logic [255:0] src_beat(input int unsigned i);
    logic [255:0] b;
    for (int unsigned k = 0; k < 8; k++) b[32*k +: 32] = 32'hA000_0000 + i * 16 + k;
    return b;
  endfunction

  // Return path: either a wire of accepted M beats (optionally corrupted) or a loopback source.
  always @(posedge clk) begin
    #1;
    if (stall) m_tready = ~m_tready;
    if (rt_lb) begin
      if (src_hs) src_idx++;
      s_tvalid = (src_idx < 15);
      s_tdata  = src_beat(src_idx);
      s_tstrb  = 32'hF0F0_0000 | src_idx;
      s_tuser  = 128'h1234 + 128'(src_idx);
      s_tlast  = (src_idx % 5 == 4);
    end else begin
      s_tvalid = m_tvalid && m_tready;
      s_tdata  = m_tdata;
      s_tstrb  = m_tstrb;
      s_tuser  = m_tuser;
      s_tlast  = m_tlast;
      if (corrupt && s_tvalid && m_tdata[31:0] == 32'd40) s_tdata[95:64] = s_tdata[95:64] ^ 32'h1;
      if (corrupt && s_tvalid && m_tdata[31:0] == 32'd32) s_tuser[0] = ~s_tuser[0];
    end
  end

  always @(negedge clk) begin
    if (rt_lb) src_hs = s_tvalid && s_tready;
    if (!rst && rt_lb && src_idx < 15 && busy) begin
      chk("lb_valid", m_tvalid, s_tvalid);
      chk("lb_data", m_tdata, s_tdata);
      chk("lb_user", m_tuser, s_tuser);
      chk("lb_strb", m_tstrb, s_tstrb);
      chk("lb_last", m_tlast, s_tlast);
      chk("lb_ready", s_tready, m_tready);
      if (s_tvalid && s_tready) begin
        tx_m++;
        rx_m++;
      end
    end
    if (!rst && gen_chk) begin
      if (m_tvalid) begin
        chk("tx_data", m_tdata, exp_beat(n_tx));
        chk("tx_last", m_tlast, (n_tx % len_m) == len_m - 1);
        chk("tx_user", m_tuser, exp_user());
        chk("tx_strb", m_tstrb, 32'hFFFF_FFFF);
        if (prev_v && !prev_r) chk("tx_hold", m_tdata, prev_d);
        if (m_tready) begin
          if (n_tx == 1) lane0_b1 = m_tdata[31:0];
          if (m_tlast && n_tx < 32) last_mask[n_tx] = 1'b1;
          n_tx++;
          tx_m++;
        end
      end else if (prev_v && !prev_r) begin
        chk("tx_hold_valid", m_tvalid, 1'b1);
      end
      prev_v = m_tvalid;
      prev_r = m_tready;
      prev_d = m_tdata;
      if (s_tvalid && s_tready) begin
        if (s_tdata != exp_beat(n_rx) || s_tlast != ((n_rx % len_m) == len_m - 1) ||
            ((n_rx % len_m) == 0 && s_tuser[23:0] != MAGIC)) err_m++;
        n_rx++;
        rx_m++;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(posedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic rdr(input logic [2:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    reg_rd = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic go(input logic [31:0] ctrl);
    n_tx = 0; n_rx = 0; last_mask = '0; lane0_b1 = '0; prev_v = 1'b0;
    if (ctrl[2]) begin tx_m = 0; rx_m = 0; err_m = 0; end
    wr(3'd0, ctrl);
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned n = 0;
    while (!done_o && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_reached", done_o, 1'b1);
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    rdr(a, rd);
    chk(name, rd, exp);
  endtask

  initial begin
    rst = 1'b1; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tlast = 1'b0;
    tx_m = 0; rx_m = 0; err_m = 0; len_m = 4; src_idx = 0;
    @(posedge clk); @(negedge clk);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_sready", s_tready, 1'b0);
    chk("rst_status", {err_o, done_o, busy}, 3'b000);
    chk("rst_rdata", reg_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk_reg("rst_pkt_len", 3'd1, 32'd1);
    chk_reg("rst_pkt_cnt", 3'd2, 32'd1);
    chk_reg("rst_tx_beats", 3'd4, 32'd0);

    // Basic generate run over a wire return path.
    wr(3'd1, 32'd4); wr(3'd2, 32'd2); len_m = 4; gen_chk = 1'b1;
    go(32'h1);
    wait_done(100);
    chk_reg("t1_tx_beats", 3'd4, 32'd8);
    chk("t1_tx_model", rd, tx_m);
    chk_reg("t1_rx_beats", 3'd5, 32'd8);
    chk_reg("t1_err_cnt", 3'd7, 32'd0);
    chk_reg("t1_cycles", 3'd6, 32'd9);
    chk_reg("t1_status", 3'd3, 32'd2);
    chk("t1_lane0_beat1", lane0_b1, 32'd8);
    chk("t1_tlast_pos", last_mask, 32'h88);

    // Stalls on M_AXIS_TREADY; clear and start in one write.
    stall = 1'b1;
    go(32'h5);
    wait_done(200);
    stall = 1'b0; m_tready = 1'b1;
    chk_reg("t2_tx_beats", 3'd4, 32'd8);
    chk_reg("t2_rx_beats", 3'd5, 32'd8);
    chk_reg("t2_err_cnt", 3'd7, 32'd0);

    // Corrupted return path: lane 2 of beat 5 and magic of beat 4.
    corrupt = 1'b1;
    go(32'h5);
    wait_done(100);
    corrupt = 1'b0;
    chk_reg("t3_err_cnt", 3'd7, 32'd2);
    chk("t3_err_model", rd, err_m);
    chk_reg("t3_status", 3'd3, 32'd6);
    wr(3'd0, 32'h4);
    chk_reg("t3_err_cleared", 3'd7, 32'd0);
    chk_reg("t3_status_clr", 3'd3, 32'd2);

    // Continuous run aborted in the middle of the third packet.
    wr(3'd2, 32'd0);
    go(32'h5);
    begin
      int unsigned n = 0;
      while (n_tx < 9 && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
    end
    wr(3'd0, 32'h8);
    wait_done(100);
    chk_reg("t4_tx_beats", 3'd4, 32'd12);
    chk("t4_tx_mult", rd % 4, 32'd0);
    chk("t4_tlast_11", last_mask[11], 1'b1);
    chk_reg("t4_rx_beats", 3'd5, 32'd12);
    chk_reg("t4_err_cnt", 3'd7, 32'd0);

    // Loopback: three packets of five beats from the bench source.
    gen_chk = 1'b0; src_idx = 0; src_hs = 1'b0; rt_lb = 1'b1;
    wr(3'd1, 32'd5); wr(3'd2, 32'd3);
    go(32'h7);
    wait_done(100);
    chk_reg("t5_tx_beats", 3'd4, 32'd15);
    chk("t5_tx_model", rd, tx_m);
    chk_reg("t5_rx_beats", 3'd5, 32'd15);
    chk_reg("t5_err_cnt", 3'd7, 32'd0);
    rt_lb = 1'b0; src_hs = 1'b0;

    // Reset in the middle of a continuous generate run.
    wr(3'd1, 32'd4); wr(3'd2, 32'd0); len_m = 4; gen_chk = 1'b1;
    go(32'h5);
    repeat (6) @(posedge clk);
    @(negedge clk);
    gen_chk = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_tvalid", m_tvalid, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_sready", s_tready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    chk_reg("t6_tx_beats", 3'd4, 32'd0);
    chk_reg("t6_rx_beats", 3'd5, 32'd0);
    chk_reg("t6_cycles", 3'd6, 32'd0);
    chk_reg("t6_err_cnt", 3'd7, 32'd0);
    chk_reg("t6_pkt_len", 3'd1, 32'd1);
    chk_reg("t6_status", 3'd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
